// File: rtl/mm_pkg.sv
// Shared types and sizes for the 2x2 matrix multiplier datapath and its output stages.
package mm_pkg;

  localparam int MM_DATA_W = 128;
  localparam int MM_ELEMS  = 4;

  typedef logic [1:0]           mm_idx_t;
  typedef logic [MM_DATA_W-1:0] mm_elem_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/matrix_result_serializer_relu.sv
// Element-wise ReLU: any element with its MSB set is replaced by zero, others pass untouched.
module matrix_result_serializer_relu #(
  parameter int DATA_W = 128
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  assign dout = din[DATA_W-1] ? '0 : din;

endmodule

// File: rtl/matrix_result_serializer.sv
// Buffers one 2x2 result matrix and streams its elements row-major, one per output handshake,
// with optional ReLU and a saturating count of clipped elements.
module matrix_result_serializer
  import mm_pkg::*;
#(
  parameter int DATA_W     = MM_DATA_W,
  parameter bit APPLY_RELU = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] c00,
  input  logic [DATA_W-1:0] c01,
  input  logic [DATA_W-1:0] c10,
  input  logic [DATA_W-1:0] c11,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic              out_last,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  clip_count
);

  ser_state_t        state_p0;
  mm_idx_t           idx_p0;
  logic [DATA_W-1:0] buf_p0 [MM_ELEMS];
  logic [CNT_W-1:0]  cnt_p0;

  logic              vld_p0;
  logic              idx_last;
  logic              accept;
  logic              out_hs;
  logic              clip_hit;
  logic [DATA_W-1:0] raw_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign vld_p0   = (state_p0 == SEND);
  assign idx_last = (idx_p0 == 2'd3);

  // Refill is allowed while the last element leaves, so matrices stream with no idle cycle.
  assign in_ready = rst_n && (!vld_p0 || (idx_last && out_ready));
  assign accept   = in_valid && in_ready;
  assign out_hs   = vld_p0 && out_ready;

  assign raw_sel    = buf_p0[idx_p0];
  assign out_valid  = vld_p0;
  assign out_idx    = idx_p0;
  assign out_last   = idx_last;
  assign clip_count = cnt_p0;
  assign clip_hit   = APPLY_RELU && out_hs && raw_sel[DATA_W-1];

  generate
    if (APPLY_RELU) begin : g_relu
      matrix_result_serializer_relu #(
        .DATA_W (DATA_W)
      ) u_relu (
        .din  (raw_sel),
        .dout (out_data)
      );
    end else begin : g_raw
      assign out_data = raw_sel;
    end
  endgenerate

  // Stage p0: matrix buffer, element index, state and clip counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      idx_p0   <= '0;
      cnt_p0   <= '0;
      for (int i = 0; i < MM_ELEMS; i++) buf_p0[i] <= '0;
    end else begin
      if (accept) begin
        buf_p0[0] <= c00;
        buf_p0[1] <= c01;
        buf_p0[2] <= c10;
        buf_p0[3] <= c11;
        idx_p0    <= '0;
        state_p0  <= SEND;
      end else if (out_hs) begin
        if (idx_last) state_p0 <= IDLE;
        else          idx_p0   <= idx_p0 + 2'd1;
      end

      if (clr_count)     cnt_p0 <= '0;
      else if (clip_hit) cnt_p0 <= sat_inc(cnt_p0);
    end
  end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Bench for matrix_result_serializer: three configurations driven in lock-step against a
// queue-based model of the element stream and clip counters.
module tb_matrix_result_serializer;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, out_ready, clr_count;
  logic [W-1:0] c00, c01, c10, c11;

  logic         ir_a, ov_a, ol_a, ir_b, ov_b, ol_b, ir_c, ov_c, ol_c;
  logic [W-1:0] od_a, od_b, od_c;
  logic [1:0]   oi_a, oi_b, oi_c;
  logic [7:0]   cc_a, cc_b;
  logic [1:0]   cc_c;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] q_data[$];
  int           q_idx[$];
  int           m_cnt_a, m_cnt_c;

  always #5 clk = ~clk;

  matrix_result_serializer #(.DATA_W(W), .APPLY_RELU(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_idx(oi_a),
    .out_last(ol_a), .clr_count(clr_count), .clip_count(cc_a));

  matrix_result_serializer #(.DATA_W(W), .APPLY_RELU(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_idx(oi_b),
    .out_last(ol_b), .clr_count(clr_count), .clip_count(cc_b));

  matrix_result_serializer #(.DATA_W(W), .APPLY_RELU(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_c),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_idx(oi_c),
    .out_last(ol_c), .clr_count(clr_count), .clip_count(cc_c));

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] relu(input logic [W-1:0] x);
    return x[W-1] ? '0 : x;
  endfunction

  function automatic logic [W-1:0] rnd_elem();
    logic [W-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 3) == 0) v = v & 128'hFF;
    return v;
  endfunction

  // Called at posedge+1; drives inputs, checks against the model, then advances one cycle.
  task automatic step(input logic iv, input logic [W-1:0] m0, input logic [W-1:0] m1,
                      input logic [W-1:0] m2, input logic [W-1:0] m3,
                      input logic ordy, input logic clr);
    logic exp_ir, exp_ov;
    in_valid = iv; c00 = m0; c01 = m1; c10 = m2; c11 = m3;
    out_ready = ordy; clr_count = clr;
    #1;
    exp_ov = (q_data.size() > 0);
    exp_ir = (q_data.size() == 0) || (q_data.size() == 1 && ordy);
    chk("in_ready_a", ir_a, exp_ir);
    chk("in_ready_b", ir_b, exp_ir);
    chk("in_ready_c", ir_c, exp_ir);
    chk("out_valid_a", ov_a, exp_ov);
    chk("out_valid_b", ov_b, exp_ov);
    chk("out_valid_c", ov_c, exp_ov);
    if (exp_ov) begin
      chk("out_data_a", od_a, relu(q_data[0]));
      chk("out_data_b", od_b, q_data[0]);
      chk("out_data_c", od_c, relu(q_data[0]));
      chk("out_idx_a", oi_a, q_idx[0]);
      chk("out_idx_b", oi_b, q_idx[0]);
      chk("out_last_a", ol_a, q_idx[0] == 3);
      chk("out_last_c", ol_c, q_idx[0] == 3);
    end
    chk("clip_a", cc_a, m_cnt_a);
    chk("clip_b", cc_b, 0);
    chk("clip_c", cc_c, m_cnt_c);

    if (exp_ov && ordy) begin
      if (q_data[0][W-1]) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_c < 3)   m_cnt_c++;
      end
      void'(q_data.pop_front());
      void'(q_idx.pop_front());
    end
    if (clr) begin
      m_cnt_a = 0;
      m_cnt_c = 0;
    end
    if (iv && exp_ir) begin
      q_data.push_back(m0); q_idx.push_back(0);
      q_data.push_back(m1); q_idx.push_back(1);
      q_data.push_back(m2); q_idx.push_back(2);
      q_data.push_back(m3); q_idx.push_back(3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ov"}, ov_a | ov_b | ov_c, 1'b0);
    chk({tag, "_ir"}, ir_a | ir_b | ir_c, 1'b0);
    chk({tag, "_cc_a"}, cc_a, 0);
    chk({tag, "_cc_c"}, cc_c, 0);
    chk({tag, "_od"}, od_a | od_b | od_c, '0);
    chk({tag, "_oi"}, oi_a | oi_b | oi_c, 0);
    chk({tag, "_ol"}, ol_a | ol_b | ol_c, 1'b0);
  endtask

  initial begin
    logic [W-1:0] neg, ones, e0, e1, e2, e3;
    neg  = {1'b1, {(W-1){1'b0}}};
    ones = '1;
    m_cnt_a = 0;
    m_cnt_c = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
    c00 = '0; c01 = '0; c10 = '0; c11 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single matrix, consumer always ready
    step(1'b1, 128'd1, 128'd2, 128'd3, 128'd4, 1'b1, 1'b0);
    idle(6);

    // ReLU on 2^127 and 2^128-1
    step(1'b1, 128'd5, neg, 128'd5, ones, 1'b1, 1'b0);
    idle(5);
    chk("relu_clip_a", cc_a, 2);

    // Backpressure pattern 1,0,0,1,...
    step(1'b1, 128'd11, neg, 128'd13, 128'd14, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++)
      step(1'b1, 128'd21, 128'd22, 128'd23, 128'd24, (i % 3) == 2, 1'b0);
    idle(6);

    // Back-to-back matrices {1..4} then {5..8}
    step(1'b1, 128'd1, 128'd2, 128'd3, 128'd4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 128'd5, 128'd6, 128'd7, 128'd8, 1'b1, 1'b0);
    idle(5);

    // Reset mid-matrix after the first element left
    step(1'b1, 128'd9, 128'd10, neg, 128'd12, 1'b1, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q_data.delete();
    q_idx.delete();
    m_cnt_a = 0;
    m_cnt_c = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 128'd1, 128'd2, 128'd3, 128'd4, 1'b1, 1'b0);
    idle(5);

    // Saturation of the 2-bit counter, then clear coincident with a negative handshake
    step(1'b1, neg, ones, neg, 128'd7, 1'b1, 1'b0);
    step(1'b1, ones, neg, 128'd1, 128'd2, 1'b1, 1'b0);
    idle(6);
    chk("sat_clip_c", cc_c, 3);
    step(1'b1, neg, 128'd1, 128'd2, 128'd3, 1'b1, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
    chk("clr_clip_c", cc_c, 0);
    chk("clr_clip_a", cc_a, 0);
    idle(5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      e0 = rnd_elem(); e1 = rnd_elem(); e2 = rnd_elem(); e3 = rnd_elem();
      step($urandom_range(0, 9) < 7, e0, e1, e2, e3,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
